// File: rtl/tq_tr4_ctrl.sv
// tq_tr4_ctrl: two-pass 4x4 forward/inverse core transform sequencer around the mcm00 multiplier.
module tq_tr4_ctrl #(
  parameter int FWD_SH1 = 1,
  parameter int FWD_SH2 = 8,
  parameter int INV_SH1 = 7,
  parameter int INV_SH2 = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inverse,
  input  logic signed [15:0] in_0,
  input  logic signed [15:0] in_1,
  input  logic signed [15:0] in_2,
  input  logic signed [15:0] in_3,
  output logic               mcm_inverse,
  output logic signed [19:0] mcm_i_0,
  output logic signed [19:0] mcm_i_1,
  output logic signed [19:0] mcm_i_2,
  output logic signed [19:0] mcm_i_3,
  input  logic signed [27:0] mcm_o_0,
  input  logic signed [27:0] mcm_o_1,
  input  logic signed [27:0] mcm_o_2,
  input  logic signed [27:0] mcm_o_3,
  output logic               out_valid,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic signed [15:0] out_0,
  output logic signed [15:0] out_1,
  output logic signed [15:0] out_2,
  output logic signed [15:0] out_3
);
  typedef enum logic [1:0] {ROW, DRAIN, COL} state_t;
  localparam logic [3:0] FS1 = 4'(FWD_SH1);
  localparam logic [3:0] FS2 = 4'(FWD_SH2);
  localparam logic [3:0] IS1 = 4'(INV_SH1);
  localparam logic [3:0] IS2 = 4'(INV_SH2);
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic acc, load, inv_nx, blk_inv;
  logic signed [15:0] t_buf [4][4];
  logic signed [19:0] s [4];
  logic signed [19:0] iss [4];
  logic signed [19:0] iss_nx [4];
  logic iss_v, iss_pass;
  logic [1:0] iss_idx;
  logic tg_v, tg_inv, tg_pass;
  logic [1:0] tg_idx;
  logic signed [28:0] o [4];
  logic signed [28:0] y [4];
  logic signed [15:0] r [4];
  logic [3:0] sh;

  function automatic logic signed [15:0] rc(input logic signed [28:0] v, input logic [3:0] sa);
    logic signed [29:0] t;
    t = (30'(v) + (30'sd1 <<< (sa - 4'd1))) >>> sa;
    return t > 30'sd32767 ? 16'sh7fff : t < -30'sd32768 ? 16'sh8000 : t[15:0];
  endfunction

  assign in_ready = state == ROW;
  assign acc = in_valid && in_ready;
  assign load = acc || state == COL;
  assign {mcm_i_0, mcm_i_1, mcm_i_2, mcm_i_3} = {iss[0], iss[1], iss[2], iss[3]};

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == ROW) begin
      cnt_nx = acc ? cnt + 2'd1 : cnt;
      state_nx = acc && cnt == 2'd3 ? DRAIN : ROW;
    end else begin
      cnt_nx = state == DRAIN && cnt == 2'd1 ? 2'd0 : cnt + 2'd1;
      state_nx = state == DRAIN ? (cnt == 2'd1 ? COL : DRAIN) : (cnt == 2'd3 ? ROW : COL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ROW;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end

  // Columns come from the transpose buffer; rows after row 0 reuse the latched block mode.
  always_comb begin
    s[0] = state == COL ? 20'(t_buf[0][cnt]) : 20'(in_0);
    s[1] = state == COL ? 20'(t_buf[1][cnt]) : 20'(in_1);
    s[2] = state == COL ? 20'(t_buf[2][cnt]) : 20'(in_2);
    s[3] = state == COL ? 20'(t_buf[3][cnt]) : 20'(in_3);
    inv_nx = state == COL || cnt != 2'd0 ? blk_inv : in_inverse;
    iss_nx[0] = inv_nx ? s[0] : s[0] + s[3];
    iss_nx[1] = inv_nx ? s[2] : s[1] + s[2];
    iss_nx[2] = inv_nx ? s[1] : s[1] - s[2];
    iss_nx[3] = inv_nx ? s[3] : s[0] - s[3];
  end

  always_comb begin
    o[0] = 29'(mcm_o_0);
    o[1] = 29'(mcm_o_1);
    o[2] = 29'(mcm_o_2);
    o[3] = 29'(mcm_o_3);
    y[0] = tg_inv ? o[0] + o[3] : o[0];
    y[1] = tg_inv ? o[1] + o[2] : o[2];
    y[2] = tg_inv ? o[1] - o[2] : o[1];
    y[3] = tg_inv ? o[0] - o[3] : o[3];
    sh = tg_pass ? (tg_inv ? IS2 : FS2) : (tg_inv ? IS1 : FS1);
    for (int k = 0; k < 4; k++) r[k] = rc(y[k], sh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_inv <= 1'b0;
      for (int k = 0; k < 4; k++) iss[k] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) t_buf[i][j] <= '0;
      mcm_inverse <= 1'b0;
      {iss_v, iss_pass, iss_idx} <= '0;
      {tg_v, tg_inv, tg_pass, tg_idx} <= '0;
      {out_valid, out_last, out_idx} <= '0;
      {out_0, out_1, out_2, out_3} <= '0;
    end else begin
      if (acc && cnt == 2'd0) blk_inv <= in_inverse;
      iss_v <= load;
      if (load) begin
        for (int k = 0; k < 4; k++) iss[k] <= iss_nx[k];
        mcm_inverse <= inv_nx;
        iss_pass <= state == COL;
        iss_idx <= cnt;
      end
      {tg_v, tg_inv, tg_pass, tg_idx} <= {iss_v, mcm_inverse, iss_pass, iss_idx};
      if (tg_v && !tg_pass)
        for (int k = 0; k < 4; k++) t_buf[tg_idx][k] <= r[k];
      out_valid <= tg_v && tg_pass;
      out_last <= tg_v && tg_pass && tg_idx == 2'd3;
      if (tg_v && tg_pass) begin
        out_idx <= tg_idx;
        {out_0, out_1, out_2, out_3} <= {r[0], r[1], r[2], r[3]};
      end
    end
  end
endmodule

// File: tb/tb_tq_tr4_ctrl.sv
// tb_tq_tr4_ctrl: scoreboard bench with a matrix-form reference transform and an mcm00 stand-in.
module tb_tq_tr4_ctrl;
  logic clk = 0, rst = 0, in_valid = 0, in_inverse = 0;
  logic signed [15:0] in_0 = 0, in_1 = 0, in_2 = 0, in_3 = 0;
  logic in_ready, mcm_inverse, out_valid, out_last;
  logic [1:0] out_idx;
  logic signed [19:0] mcm_i_0, mcm_i_1, mcm_i_2, mcm_i_3;
  logic signed [27:0] mcm_o_0, mcm_o_1, mcm_o_2, mcm_o_3;
  logic signed [15:0] out_0, out_1, out_2, out_3;

  typedef struct {int idx; int v[4];} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int mm[4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83}, '{64, -64, -64, 64}, '{36, -83, 83, -36}};
  logic signed [15:0] xb[4][4];
  bit mode, b2b;

  always #5 clk = ~clk;

  tq_tr4_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .mcm_inverse(mcm_inverse), .mcm_i_0(mcm_i_0), .mcm_i_1(mcm_i_1), .mcm_i_2(mcm_i_2), .mcm_i_3(mcm_i_3),
    .mcm_o_0(mcm_o_0), .mcm_o_1(mcm_o_1), .mcm_o_2(mcm_o_2), .mcm_o_3(mcm_o_3),
    .out_valid(out_valid), .out_idx(out_idx), .out_last(out_last),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3)
  );

  // mcm00 stand-in: even part 64*(a+/-b), odd part 83/36 rotation whose orientation follows inverse.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      {mcm_o_0, mcm_o_1, mcm_o_2, mcm_o_3} <= '0;
    end else begin
      mcm_o_0 <= 28'(64 * (int'(mcm_i_0) + int'(mcm_i_1)));
      mcm_o_1 <= 28'(64 * (int'(mcm_i_0) - int'(mcm_i_1)));
      mcm_o_2 <= mcm_inverse ? 28'(36 * int'(mcm_i_2) - 83 * int'(mcm_i_3)) : 28'(83 * int'(mcm_i_3) + 36 * int'(mcm_i_2));
      mcm_o_3 <= mcm_inverse ? 28'(83 * int'(mcm_i_2) + 36 * int'(mcm_i_3)) : 28'(36 * int'(mcm_i_3) - 83 * int'(mcm_i_2));
    end
  end

  task automatic chk(input bit ok, input string nm, input int a, input int e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
    end
  endtask

  function automatic int rnd(input int v, input int s);
    int t;
    t = (v + (1 << (s - 1))) >>> s;
    return t > 32767 ? 32767 : t < -32768 ? -32768 : t;
  endfunction

  task automatic push_block();
    int t[4][4];
    int a;
    exp_t e;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        a = 0;
        for (int j = 0; j < 4; j++) a += (mode ? mm[j][k] : mm[k][j]) * int'(xb[r][j]);
        t[r][k] = rnd(a, mode ? 7 : 1);
      end
    for (int c = 0; c < 4; c++) begin
      e.idx = c;
      for (int k = 0; k < 4; k++) begin
        a = 0;
        for (int r = 0; r < 4; r++) a += (mode ? mm[r][k] : mm[k][r]) * t[r][c];
        e.v[k] = rnd(a, mode ? 12 : 8);
      end
      q.push_back(e);
    end
  endtask

  task automatic send_row(input int r, input bit inv, input int gap);
    bit a;
    int n = 0;
    repeat (gap) begin
      in_valid = 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    {in_0, in_1, in_2, in_3} = {xb[r][0], xb[r][1], xb[r][2], xb[r][3]};
    in_inverse = inv;
    do begin
      a = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 100);
    if (!a) chk(0, "accept_timeout", n, 100);
  endtask

  task automatic run_block(input int gmin, input int gmax, input bit keep);
    push_block();
    for (int r = 0; r < 4; r++) send_row(r, r == 0 ? mode : 1'($urandom), $urandom_range(gmax, gmin));
    if (!keep) in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(q.size() == 0, "drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_dc_fwd();
    mode = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) xb[i][j] = 16'sd1;
  endtask

  task automatic fill_dc_inv();
    mode = 1;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) xb[i][j] = 16'sd0;
    xb[0][0] = 16'sd64;
  endtask

  // Monitor: cycle-level timing expectations derived from accepts, plus the scoreboard pop.
  int n = 0, rows = 0, k4 = -100, b2b_seen = 0;
  bit blk_mode;
  bit mi_v[64];
  bit mi_e[64];
  always @(negedge clk) begin
    exp_t e;
    n++;
    if (!rst) begin
      rows = 0;
      k4 = -100;
      b2b_seen = 0;
      for (int i = 0; i < 64; i++) mi_v[i] = 0;
      chk(in_ready == 1, "rst_in_ready", int'(in_ready), 1);
      chk(!out_valid && !out_last && out_idx == 0, "rst_out_ctl", int'({out_valid, out_last, out_idx}), 0);
      chk(out_0 == 0 && out_1 == 0 && out_2 == 0 && out_3 == 0, "rst_out_data", int'(out_0), 0);
      chk(mcm_i_0 == 0 && mcm_i_1 == 0 && mcm_i_2 == 0 && mcm_i_3 == 0 && !mcm_inverse, "rst_mcm", int'(mcm_i_0), 0);
    end else begin
      chk(in_ready == !(n >= k4 + 1 && n <= k4 + 6), "in_ready", int'(in_ready), int'(!(n >= k4 + 1 && n <= k4 + 6)));
      chk(out_valid == (n >= k4 + 6 && n <= k4 + 9), "out_valid", int'(out_valid), int'(n >= k4 + 6 && n <= k4 + 9));
      if (mi_v[n % 64]) begin
        chk(mcm_inverse == mi_e[n % 64], "mcm_inverse", int'(mcm_inverse), int'(mi_e[n % 64]));
        mi_v[n % 64] = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) chk(0, "unexpected_out", int'(out_idx), -1);
        else begin
          e = q.pop_front();
          chk(out_idx == 2'(e.idx), "out_idx", int'(out_idx), e.idx);
          chk(out_last == (e.idx == 3), "out_last", int'(out_last), int'(e.idx == 3));
          chk(out_0 == 16'(e.v[0]), $sformatf("out_0_c%0d", e.idx), int'(out_0), e.v[0]);
          chk(out_1 == 16'(e.v[1]), $sformatf("out_1_c%0d", e.idx), int'(out_1), e.v[1]);
          chk(out_2 == 16'(e.v[2]), $sformatf("out_2_c%0d", e.idx), int'(out_2), e.v[2]);
          chk(out_3 == 16'(e.v[3]), $sformatf("out_3_c%0d", e.idx), int'(out_3), e.v[3]);
        end
      end
      if (in_valid && in_ready) begin
        if (rows == 0) blk_mode = in_inverse;
        mi_v[(n + 1) % 64] = 1;
        mi_e[(n + 1) % 64] = blk_mode;
        rows++;
        if (rows == 4) begin
          if (b2b && b2b_seen > 0) chk(n - k4 == 10, "b2b_period", n - k4, 10);
          b2b_seen = b2b ? b2b_seen + 1 : 0;
          k4 = n;
          rows = 0;
          for (int j = 4; j < 8; j++) begin
            mi_v[(n + j) % 64] = 1;
            mi_e[(n + j) % 64] = blk_mode;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    fill_dc_fwd();
    run_block(0, 0, 0);
    wait_idle();
    fill_dc_inv();
    run_block(0, 0, 0);
    wait_idle();
    mode = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) xb[i][j] = 16'sd32767;
    run_block(0, 0, 0);
    wait_idle();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) xb[i][j] = 16'($urandom);
    run_block(1, 3, 0);
    wait_idle();
    b2b = 1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) fill_dc_fwd();
      else fill_dc_inv();
      run_block(0, 0, i < 5);
    end
    wait_idle();
    b2b = 0;
    fill_dc_fwd();
    send_row(0, 0, 0);
    send_row(1, 0, 0);
    in_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk(in_ready == 1, "ready_after_reset", int'(in_ready), 1);
    run_block(0, 0, 0);
    wait_idle();
    for (int b = 0; b < 40; b++) begin
      mode = 1'($urandom);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          xb[i][j] = $urandom_range(2, 0) == 0 ? 16'($urandom) : 16'(int'($urandom_range(400, 0)) - 200);
      run_block(0, 3, 0);
      if ($urandom_range(3, 0) == 0) wait_idle();
    end
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
